uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 13 +
 rtl/uart_tx_fifo_mem.sv | 28 ++
 rtl/uart_tx_fifo.sv | 119 +++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart byte buffers: byte width and the
// drain-controller state encoding, reused by the TX and RX-side buffers.
package uart_tx_fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port and a
// combinational read port that always shows the entry at raddr.
module sync_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Store the pushed byte; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the uart transmitter. Producers push at clock rate;
// a small FSM pops one byte at a time into the uart din/wr_en/wr_rdy port,
// with a guard cycle after every strobe so the transmitter can drop ready.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [BYTE_W-1:0] tx_din,
    output logic              tx_wr_en,
    input  logic              tx_wr_rdy,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_din_q, tx_din_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic [BYTE_W-1:0] rd_data;
    logic              push;
    logic              pop;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = (state_q == IDLE) && !empty && tx_wr_rdy;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Pointer, occupancy and sticky overflow next-state; pointers wrap at DEPTH.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (wr_valid & full);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state: IDLE -> ISSUE on pop, then one GUARD cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = pop ? ISSUE : IDLE;
            ISSUE:   state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM outputs: strobe for the cycle after a pop, din held until next pop.
    always_comb begin
        tx_wr_en_d = pop;
        tx_din_d   = pop ? rd_data : tx_din_q;
    end

    // Registered uart-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_din_q   <= '0;
            tx_wr_en_q <= 1'b0;
        end else begin
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
        end
    end

    assign tx_din   = tx_din_q;
    assign tx_wr_en = tx_wr_en_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. The reference model is a byte queue
// plus the strobe rule: a byte leaves on an edge when ready is high, the queue
// is non-empty, and at least 3 edges have passed since the previous strobe.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic       tx_wr_rdy;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [7:0] model_q [$];
    logic [7:0] din_m;
    logic       ovf_m;
    int         edge_n;
    int         last_strobe;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_wr_rdy (tx_wr_rdy),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        model_q.delete();
        din_m       = 8'h00;
        ovf_m       = 1'b0;
        last_strobe = edge_n - 100;
    endtask

    // One clock: drive inputs at negedge, advance the model, check at next negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy);
        int sz;
        bit exp_strobe;
        bit accept;
        int exp_cnt;
        wr_valid   = v;
        wr_data    = d;
        tx_wr_rdy  = rdy;
        sz         = model_q.size();
        exp_strobe = rdy && (sz > 0) && (edge_n - last_strobe >= 3);
        accept     = v && (sz < DEPTH);
        if (v && sz == DEPTH) ovf_m = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (exp_strobe) begin
            din_m       = model_q.pop_front();
            last_strobe = edge_n;
        end
        if (accept) model_q.push_back(d);
        edge_n++;
        exp_cnt = model_q.size();
        if (tx_wr_en === 1'b1) $display("tx byte %02h at edge %0d", tx_din, edge_n);

        compared++;
        if (tx_wr_en !== exp_strobe) begin
            mismatched++;
            $display("FAIL strobe edge %0d: got %b want %b", edge_n, tx_wr_en, exp_strobe);
        end
        compared++;
        if (tx_din !== din_m) begin
            mismatched++;
            $display("FAIL tx_din edge %0d: got %02h want %02h", edge_n, tx_din, din_m);
        end
        compared++;
        if (count !== 5'(exp_cnt)) begin
            mismatched++;
            $display("FAIL count edge %0d: got %0d want %0d", edge_n, count, exp_cnt);
        end
        compared++;
        if ({full, empty, wr_ready} !== {exp_cnt == DEPTH, exp_cnt == 0, exp_cnt != DEPTH}) begin
            mismatched++;
            $display("FAIL flags edge %0d: got full/empty/rdy %b%b%b for count %0d",
                     edge_n, full, empty, wr_ready, exp_cnt);
        end
        compared++;
        if (overflow !== ovf_m) begin
            mismatched++;
            $display("FAIL overflow edge %0d: got %b want %b", edge_n, overflow, ovf_m);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic test_reset();
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(i + 8'h30), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({count, empty, full, wr_ready, tx_wr_en, overflow, tx_din} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            mismatched++;
            $display("FAIL async_reset: got cnt=%0d e=%b f=%b rdy=%b en=%b ovf=%b din=%02h want 0 1 0 1 0 0 00",
                     count, empty, full, wr_ready, tx_wr_en, overflow, tx_din);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        compared++;
        if (tx_wr_en !== 1'b1 || tx_din !== 8'hA5) begin
            mismatched++;
            $display("FAIL single_latency: got en=%b din=%02h want en=1 din=a5", tx_wr_en, tx_din);
        end
        idle(5, 1'b1);
        compared++;
        if (count !== 5'd0) begin
            mismatched++;
            $display("FAIL single_drain: got count %0d want 0", count);
        end
    endtask

    task automatic test_burst();
        int strobes = 0;
        int first   = -1;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (tx_wr_en === 1'b1) begin
                if (first < 0) first = edge_n;
                strobes++;
            end
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (tx_wr_en === 1'b1) strobes++;
        end
        compared++;
        if (strobes != 5 || empty !== 1'b1) begin
            mismatched++;
            $display("FAIL burst: got %0d strobes empty=%b want 5 strobes empty=1", strobes, empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        compared++;
        if (count !== 5'd16 || full !== 1'b1 || wr_ready !== 1'b0 || overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL full: got cnt=%0d f=%b rdy=%b ovf=%b want 16 1 0 1", count, full, wr_ready, overflow);
        end
        idle(3 * DEPTH + 6, 1'b1);
        compared++;
        if (count !== 5'd0 || tx_din !== 8'hCF || overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL full_drain: got cnt=%0d last=%02h ovf=%b want 0 cf 1", count, tx_din, overflow);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        step(1'b1, 8'h7F, 1'b1);
        compared++;
        if (count !== 5'd3 || tx_wr_en !== 1'b1 || tx_din !== 8'h70) begin
            mismatched++;
            $display("FAIL push_pop: got cnt=%0d en=%b din=%02h want 3 1 70", count, tx_wr_en, tx_din);
        end
        idle(14, 1'b1);
        compared++;
        if (tx_din !== 8'h7F || count !== 5'd0) begin
            mismatched++;
            $display("FAIL push_pop_order: got last=%02h cnt=%0d want 7f 0", tx_din, count);
        end
    endtask

    task automatic test_backpressure_reset();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        idle(6, 1'b0);
        compared++;
        if (count !== 5'd2 || tx_wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_off: got cnt=%0d en=%b want 2 0", count, tx_wr_en);
        end
        step(1'b0, 8'h00, 1'b1);
        compared++;
        if (tx_wr_en !== 1'b1 || tx_din !== 8'h11) begin
            mismatched++;
            $display("FAIL release: got en=%b din=%02h want 1 11", tx_wr_en, tx_din);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (tx_wr_en !== 1'b0 || count !== 5'd0) begin
            mismatched++;
            $display("FAIL reset_mid_issue: got en=%b cnt=%0d want 0 0", tx_wr_en, count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0);
        end
        idle(3 * DEPTH + 6, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        tx_wr_rdy = 1'b0;
        edge_n    = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single();
        test_burst();
        test_full();
        test_reset();
        test_simultaneous();
        test_backpressure_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
